// File: rtl/hall_call_collector.sv
// Hall call front end: synchronise and debounce landing buttons, latch pending calls,
// clear them when a lift serves the landing, and stream new calls to the arbiter.

module hall_call_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic accept
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    accept  = 1'b0;
    if (!sync2_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      // fire on the edge the count reaches the threshold; armed blocks repeats while held
      if (armed_q && cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end
endmodule

module hall_call_collector #(
  parameter int N_FLOORS        = 12,
  parameter int N_LIFTS         = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_FLOORS-1:0]           btn_up,
  input  logic [N_FLOORS-1:0]           btn_dn,
  input  logic [N_LIFTS-1:0]            door_open,
  input  logic [N_LIFTS-1:0]            direction,
  input  logic [N_LIFTS*N_FLOORS-1:0]   floor_sense,
  output logic [N_FLOORS-1:0]           hall_up_pending,
  output logic [N_FLOORS-1:0]           hall_dn_pending,
  output logic                          call_valid,
  output logic [$clog2(N_FLOORS)-1:0]   call_floor,
  output logic                          call_dir,
  input  logic                          call_ready
);
  localparam int NS = 2 * N_FLOORS;
  localparam int SW = $clog2(NS);
  localparam int FW = $clog2(N_FLOORS);
  // slots: up0..upN-1 then dn0..dnN-1; up at top and down at bottom do not exist
  localparam logic [NS-1:0] SLOT_MASK = ~((NS'(1) << (N_FLOORS - 1)) | (NS'(1) << N_FLOORS));

  typedef enum logic {IDLE, OFFER} state_t;

  logic [NS-1:0] raw_slot, acc, acc_m, clr;
  logic [NS-1:0] pend_q, pend_d, new_q, new_d;
  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, slot_q, slot_d, hit_slot;
  logic [FW-1:0] floor_q, floor_d, hit_floor;
  logic          valid_q, valid_d, dir_q, dir_d, hit_up, found, hs;

  assign raw_slot = {btn_dn, btn_up};
  assign acc_m    = acc & SLOT_MASK;

  for (genvar s = 0; s < NS; s++) begin : g_db
    hall_call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_slot[s]),
      .accept (acc[s])
    );
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_LIFTS; i++)
      for (int f = 0; f < N_FLOORS; f++)
        if (door_open[i] && floor_sense[i*N_FLOORS + f]) begin
          if (direction[i]) clr[f] = 1'b1;
          else              clr[N_FLOORS + f] = 1'b1;
        end
  end

  // round-robin search for the first new call at or after ptr
  always_comb begin
    int idx;
    found     = 1'b0;
    hit_slot  = '0;
    hit_floor = '0;
    hit_up    = 1'b0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NS) idx = idx - NS;
      if (!found && new_q[idx]) begin
        found     = 1'b1;
        hit_slot  = SW'(idx);
        hit_up    = (idx < N_FLOORS);
        hit_floor = (idx >= N_FLOORS) ? FW'(idx - N_FLOORS) : FW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    hs      = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        slot_d  = hit_slot;
        floor_d = hit_floor;
        dir_d   = hit_up;
        valid_d = 1'b1;
        state_d = OFFER;
      end
      OFFER: if (call_ready) begin
        hs      = 1'b1;
        valid_d = 1'b0;
        ptr_d   = (slot_q == SW'(NS - 1)) ? '0 : slot_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // service clear dominates a same-cycle press; a repeat press of a lit call is not re-offered
  always_comb begin
    pend_d = (pend_q | acc_m) & ~clr;
    new_d  = (new_q | (acc_m & ~pend_q)) & ~clr;
    if (hs) new_d[slot_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
      floor_q <= '0;
      dir_q   <= 1'b0;
      pend_q  <= '0;
      new_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      new_q   <= new_d;
    end
  end

  assign hall_up_pending = pend_q[N_FLOORS-1:0];
  assign hall_dn_pending = pend_q[NS-1:N_FLOORS];
  assign call_valid      = valid_q;
  assign call_floor      = floor_q;
  assign call_dir        = dir_q;
endmodule

// File: tb/tb_hall_call_collector.sv
// Bench for hall_call_collector: debounce vector table, directed corner sequences,
// and randomized traffic against a slot-level reference model.

module tb_hall_call_collector;
  localparam int NF = 12;
  localparam int NL = 10;
  localparam int DB = 4;
  localparam int NS = 2 * NF;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NF-1:0]      btn_up = '0, btn_dn = '0;
  logic [NL-1:0]      door_open = '0, direction = '0;
  logic [NL*NF-1:0]   floor_sense = '0;
  logic [NF-1:0]      hall_up_pending, hall_dn_pending;
  logic               call_valid, call_dir;
  logic [3:0]         call_floor;
  logic               call_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  hall_call_collector #(.N_FLOORS(NF), .N_LIFTS(NL), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .door_open(door_open), .direction(direction), .floor_sense(floor_sense),
    .hall_up_pending(hall_up_pending), .hall_dn_pending(hall_dn_pending),
    .call_valid(call_valid), .call_floor(call_floor), .call_dir(call_dir),
    .call_ready(call_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn_up = '0; btn_dn = '0; door_open = '0; direction = '0; floor_sense = '0;
    call_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (call_valid) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- reference model ----------------
  int m_d1[NS], m_d2[NS], m_run[NS];
  bit m_pend[NS], m_new[NS];
  bit m_off;
  int m_slot, m_ptr;

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_d1[s] = 0; m_d2[s] = 0; m_run[s] = 0; m_pend[s] = 0; m_new[s] = 0;
    end
    m_off = 0; m_slot = 0; m_ptr = 0;
  endtask

  // one clock edge with the inputs currently driven
  task automatic model_step();
    bit acc[NS];
    bit clr[NS];
    bit hs;
    int pick, s, raw;
    hs   = m_off && call_ready;
    pick = -1;
    if (!m_off)
      for (int k = 0; k < NS; k++) begin
        s = (m_ptr + k) % NS;
        if (pick < 0 && m_new[s]) pick = s;
      end
    for (int b = 0; b < NS; b++) begin
      raw = (b < NF) ? int'(btn_up[b]) : int'(btn_dn[b-NF]);
      if (m_d2[b] != 0) m_run[b] = (m_run[b] > DB) ? DB + 1 : m_run[b] + 1;
      else              m_run[b] = 0;
      acc[b] = (m_d2[b] != 0) && (m_run[b] == DB) && (b != NF - 1) && (b != NF);
      m_d2[b] = m_d1[b];
      m_d1[b] = raw;
      clr[b] = 1'b0;
    end
    for (int i = 0; i < NL; i++)
      if (door_open[i])
        for (int f = 0; f < NF; f++)
          if (floor_sense[i*NF + f]) clr[direction[i] ? f : NF + f] = 1'b1;
    for (int b = 0; b < NS; b++) begin
      if (acc[b] && !m_pend[b]) m_new[b] = 1;
      if (acc[b]) m_pend[b] = 1;
      if (clr[b]) begin m_pend[b] = 0; m_new[b] = 0; end
    end
    if (hs) begin
      m_new[m_slot] = 0;
      m_ptr = (m_slot + 1) % NS;
      m_off = 0;
    end else if (pick >= 0) begin
      m_off  = 1;
      m_slot = pick;
    end
  endtask

  typedef struct {
    int floor;
    bit up;
    int len;
    bit exp_pend;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit ok, stable;
    int got;
    int fl[3], dr[3], cy[3];
    logic [NF-1:0] up_v, dn_v;

    tbl[0] = '{3, 1'b1, 10, 1'b1};
    tbl[1] = '{5, 1'b0, 2,  1'b0};
    tbl[2] = '{5, 1'b0, 3,  1'b0};
    tbl[3] = '{5, 1'b0, 4,  1'b1};
    tbl[4] = '{11, 1'b1, 20, 1'b0};
    tbl[5] = '{0, 1'b0, 20, 1'b0};
    tbl[6] = '{0, 1'b1, 4,  1'b1};
    tbl[7] = '{11, 1'b0, 5, 1'b1};

    // reset state
    tick();
    chk("reset up_pending", 32'(hall_up_pending), 0);
    chk("reset dn_pending", 32'(hall_dn_pending), 0);
    chk("reset call_valid", 32'(call_valid), 0);
    chk("reset call_floor", 32'(call_floor), 0);
    chk("reset call_dir",   32'(call_dir), 0);

    // pulse-length table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (tbl[v].up) btn_up[tbl[v].floor] = 1'b1;
      else           btn_dn[tbl[v].floor] = 1'b1;
      repeat (tbl[v].len) tick();
      btn_up = '0; btn_dn = '0;
      repeat (10) tick();
      chk($sformatf("tbl%0d pending", v),
          32'(tbl[v].up ? hall_up_pending[tbl[v].floor] : hall_dn_pending[tbl[v].floor]),
          32'(tbl[v].exp_pend));
      chk($sformatf("tbl%0d valid", v), 32'(call_valid), 32'(tbl[v].exp_pend));
      chk($sformatf("tbl%0d floor", v), 32'(call_floor), tbl[v].exp_pend ? tbl[v].floor : 0);
      chk($sformatf("tbl%0d dir", v), 32'(call_dir), 32'(tbl[v].exp_pend & tbl[v].up));
    end

    // latency and single offer for a held button
    do_reset();
    btn_up[3] = 1'b1;
    repeat (5) tick();
    chk("lat pending before edge5", 32'(hall_up_pending[3]), 0);
    tick();
    chk("lat pending after edge5", 32'(hall_up_pending[3]), 1);
    chk("lat valid after edge5", 32'(call_valid), 0);
    tick();
    chk("lat valid after edge6", 32'(call_valid), 1);
    chk("lat floor", 32'(call_floor), 3);
    chk("lat dir", 32'(call_dir), 1);
    call_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (call_valid) got++;
      if (i == 3) btn_up[3] = 1'b0;
      tick();
    end
    chk("held button offers", 32'(got), 1);

    // three simultaneous presses served round-robin from slot 0
    do_reset();
    call_ready = 1'b1;
    btn_up[2] = 1'b1; btn_up[9] = 1'b1; btn_dn[7] = 1'b1;
    got = 0;
    for (int i = 0; i < 3; i++) begin fl[i] = -1; dr[i] = -1; cy[i] = -100; end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (call_valid && got < 3) begin
        fl[got] = int'(call_floor); dr[got] = int'(call_dir); cy[got] = c; got++;
      end
    end
    chk("rr count", 32'(got), 3);
    chk("rr0 floor", 32'(fl[0]), 2);  chk("rr0 dir", 32'(dr[0]), 1);
    chk("rr1 floor", 32'(fl[1]), 9);  chk("rr1 dir", 32'(dr[1]), 1);
    chk("rr2 floor", 32'(fl[2]), 7);  chk("rr2 dir", 32'(dr[2]), 0);
    chk("rr gap01", 32'(cy[1] - cy[0]), 2);
    chk("rr gap12", 32'(cy[2] - cy[1]), 2);

    // backpressure stability, then service clears
    do_reset();
    btn_dn[4] = 1'b1;
    wait_valid(20, ok);
    chk("bp offer seen", 32'(ok), 1);
    btn_dn[4] = 1'b0;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!(call_valid === 1'b1 && call_floor === 4'd4 && call_dir === 1'b0)) stable = 1'b0;
    end
    chk("bp stable 20 cycles", 32'(stable), 1);
    call_ready = 1'b1;
    tick();
    chk("bp accepted", 32'(call_valid), 0);
    call_ready = 1'b0;
    chk("bp dn4 still pending", 32'(hall_dn_pending[4]), 1);
    btn_up[4] = 1'b1;
    repeat (8) tick();
    btn_up[4] = 1'b0;
    repeat (4) tick();
    chk("svc up4 pending", 32'(hall_up_pending[4]), 1);
    floor_sense[6*NF + 4] = 1'b1; door_open[6] = 1'b1; direction[6] = 1'b0;
    tick();
    chk("svc dn4 cleared", 32'(hall_dn_pending[4]), 0);
    chk("svc up4 kept", 32'(hall_up_pending[4]), 1);
    direction[6] = 1'b1;
    tick();
    chk("svc up4 cleared", 32'(hall_up_pending[4]), 0);
    chk("svc no retraction valid", 32'(call_valid), 1);
    chk("svc no retraction floor", 32'(call_floor), 4);
    door_open = '0; floor_sense = '0;
    call_ready = 1'b1;
    tick();
    call_ready = 1'b0;
    repeat (3) tick();
    chk("svc no reoffer", 32'(call_valid), 0);

    // ignored buttons, then async reset mid-offer
    do_reset();
    btn_up[NF-1] = 1'b1; btn_dn[0] = 1'b1;
    repeat (15) tick();
    chk("ignored up", 32'(hall_up_pending), 0);
    chk("ignored dn", 32'(hall_dn_pending), 0);
    chk("ignored valid", 32'(call_valid), 0);
    btn_up = '0; btn_dn = '0;
    btn_up[1] = 1'b1;
    wait_valid(20, ok);
    chk("mid-offer seen", 32'(ok), 1);
    chk("mid-offer pending", 32'(hall_up_pending), 32'h002);
    #2 reset = 1'b0;
    #1;
    chk("async reset valid", 32'(call_valid), 0);
    chk("async reset pending", 32'(hall_up_pending), 0);
    btn_up = '0;

    // randomized traffic against the reference model
    do_reset();
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      for (int f = 0; f < NF; f++) begin
        up_v[f] = m_pend[f];
        dn_v[f] = m_pend[NF + f];
      end
      chk("rnd up_pending", 32'(hall_up_pending), 32'(up_v));
      chk("rnd dn_pending", 32'(hall_dn_pending), 32'(dn_v));
      chk("rnd valid", 32'(call_valid), 32'(m_off));
      if (m_off) begin
        chk("rnd floor", 32'(call_floor), m_slot % NF);
        chk("rnd dir", 32'(call_dir), 32'(m_slot < NF));
      end
      for (int f = 0; f < NF; f++) begin
        if ($urandom_range(0, 7) == 0) btn_up[f] = ~btn_up[f];
        if ($urandom_range(0, 7) == 0) btn_dn[f] = ~btn_dn[f];
      end
      floor_sense = '0;
      for (int i = 0; i < NL; i++) begin
        door_open[i] = ($urandom_range(0, 5) == 0);
        direction[i] = 1'($urandom_range(0, 1));
        floor_sense[i*NF + int'($urandom_range(0, NF - 1))] = 1'b1;
      end
      call_ready = 1'($urandom_range(0, 1));
      model_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
